// File: rtl/sram_arbiter_pkg.sv
// Shared types and limits for the SRAM arbiter.
//   state_e   : controller state (INIT zero-fill, RUN arbitration)
//   MaxNumReq : largest supported requester count
//   MinNumReq : smallest supported requester count
package sram_arbiter_pkg;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int unsigned MinNumReq = 2;
  localparam int unsigned MaxNumReq = 4;

endpackage

// File: rtl/sram_arb_rr.sv
// Round-robin pick: one-hot grant to the first requester at or after ptr_i.
//   req_i : per-requester request
//   ptr_i : search start position (0..NumReq-1)
//   gnt_o : one-hot grant, all-zero when nobody requests (combinational)
module sram_arb_rr #(
  parameter int unsigned NumReq = 2,
  localparam int unsigned PtrW  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [PtrW-1:0]   ptr_i,
  output logic [NumReq-1:0] gnt_o
);

  logic [PtrW-1:0] idx;
  logic            found;

  // Walk the requesters starting at the pointer, wrapping modulo NumReq.
  always_comb begin
    gnt_o = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      idx = PtrW'((32'(ptr_i) + k) % NumReq);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Single-port SRAM arbiter with optional zero-fill after reset.
//   clk_i, rst_ni           : clock, async active-low reset
//   req_i/gnt_o             : per-requester request / same-cycle grant
//   we_i, addr_i            : per-requester write enable and word address
//   wdata_i, wmask_i        : per-requester write data and bit mask
//   rdata_o, rvalid_o       : broadcast read data, per-requester read valid
//   ram_*_o, ram_rdata_i    : single RAM port (read data 1 cycle latency)
//   init_done_o             : high while the RAM is usable (RUN)
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned Aw       = 14,
  parameter int unsigned Dw       = 32,
  parameter int unsigned NumReq   = 2,
  parameter bit          InitZero = 1'b1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NumReq-1:0]            req_i,
  output logic [NumReq-1:0]            gnt_o,
  input  logic [NumReq-1:0]            we_i,
  input  logic [NumReq-1:0][Aw-1:0]    addr_i,
  input  logic [NumReq-1:0][Dw-1:0]    wdata_i,
  input  logic [NumReq-1:0][Dw-1:0]    wmask_i,
  output logic [Dw-1:0]                rdata_o,
  output logic [NumReq-1:0]            rvalid_o,
  output logic                         ram_req_o,
  output logic                         ram_we_o,
  output logic [Aw-1:0]                ram_addr_o,
  output logic [Dw-1:0]                ram_wdata_o,
  output logic [Dw-1:0]                ram_wmask_o,
  input  logic [Dw-1:0]                ram_rdata_i,
  output logic                         init_done_o
);

  localparam int unsigned PtrW       = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam state_e      ResetState = InitZero ? INIT : RUN;

  if (NumReq < MinNumReq || NumReq > MaxNumReq) begin : g_bad_numreq
    $error("sram_arbiter: NumReq out of supported range");
  end

  state_e              state_q, state_d;
  logic [Aw-1:0]       cnt_q, cnt_d;
  logic                arm_q, arm_d;
  logic [PtrW-1:0]     ptr_q, ptr_d;
  logic [NumReq-1:0]   rvalid_q, rvalid_d;

  logic [NumReq-1:0]   rr_gnt;
  logic [PtrW-1:0]     gnt_idx;
  logic                gnt_any;

  sram_arb_rr #(
    .NumReq (NumReq)
  ) u_rr (
    .req_i  (req_i),
    .ptr_i  (ptr_q),
    .gnt_o  (rr_gnt)
  );

  // One-hot grant to binary index for the request mux.
  always_comb begin
    gnt_idx = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (rr_gnt[i]) gnt_idx = PtrW'(i);
    end
  end

  assign gnt_any = |rr_gnt;

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ResetState;
      cnt_q    <= '0;
      arm_q    <= 1'b0;
      ptr_q    <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      arm_q    <= arm_d;
      ptr_q    <= ptr_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Next state. arm_q holds off the first fill write until one clock after
  // reset release, so the RAM port stays idle while reset is asserted.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    arm_d    = 1'b1;
    ptr_d    = ptr_q;
    rvalid_d = '0;
    case (state_q)
      INIT: begin
        if (arm_q) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == '1) state_d = RUN;
        end
      end
      RUN: begin
        if (gnt_any) begin
          ptr_d    = (gnt_idx == PtrW'(NumReq - 1)) ? '0 : gnt_idx + 1'b1;
          rvalid_d = rr_gnt & ~we_i;
        end
      end
      default: state_d = ResetState;
    endcase
  end

  // RAM port and grant outputs.
  always_comb begin
    gnt_o       = '0;
    ram_req_o   = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    ram_wmask_o = '0;
    case (state_q)
      INIT: begin
        if (arm_q) begin
          ram_req_o   = 1'b1;
          ram_we_o    = 1'b1;
          ram_addr_o  = cnt_q;
          ram_wmask_o = '1;
        end
      end
      RUN: begin
        gnt_o = rr_gnt;
        if (gnt_any) begin
          ram_req_o   = 1'b1;
          ram_we_o    = we_i[gnt_idx];
          ram_addr_o  = addr_i[gnt_idx];
          ram_wdata_o = wdata_i[gnt_idx];
          ram_wmask_o = wmask_i[gnt_idx];
        end
      end
      default: ;
    endcase
  end

  assign rvalid_o    = rvalid_q;
  assign rdata_o     = ram_rdata_i;
  assign init_done_o = (state_q == RUN);

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: a 2-requester zero-fill instance with a
// RAM model, plus a 3-requester instance without zero-fill.
module tb_sram_arbiter;

  localparam int unsigned Aw = 4;
  localparam int unsigned Dw = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit b_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: NumReq=2, InitZero=1
  logic                  rst_n;
  logic [1:0]            req, gnt, we, rvalid;
  logic [1:0][Aw-1:0]    addr;
  logic [1:0][Dw-1:0]    wdata, wmask;
  logic [Dw-1:0]         rdata, ram_wdata, ram_wmask, ram_rdata;
  logic                  ram_req, ram_we, init_done;
  logic [Aw-1:0]         ram_addr;

  sram_arbiter #(.Aw(Aw), .Dw(Dw), .NumReq(2), .InitZero(1'b1)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .we_i(we),
    .addr_i(addr), .wdata_i(wdata), .wmask_i(wmask), .rdata_o(rdata),
    .rvalid_o(rvalid), .ram_req_o(ram_req), .ram_we_o(ram_we),
    .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_wmask_o(ram_wmask),
    .ram_rdata_i(ram_rdata), .init_done_o(init_done)
  );

  // Instance B: NumReq=3, InitZero=0
  logic                  rst_nb;
  logic [2:0]            req_b, gnt_b, we_b, rvalid_b;
  logic [2:0][Aw-1:0]    addr_b;
  logic [2:0][Dw-1:0]    wdata_b, wmask_b;
  logic [Dw-1:0]         rdata_b, ram_wdata_b, ram_wmask_b, ram_rdata_b;
  logic                  ram_req_b, ram_we_b, init_done_b;
  logic [Aw-1:0]         ram_addr_b;

  sram_arbiter #(.Aw(Aw), .Dw(Dw), .NumReq(3), .InitZero(1'b0)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_nb), .req_i(req_b), .gnt_o(gnt_b), .we_i(we_b),
    .addr_i(addr_b), .wdata_i(wdata_b), .wmask_i(wmask_b), .rdata_o(rdata_b),
    .rvalid_o(rvalid_b), .ram_req_o(ram_req_b), .ram_we_o(ram_we_b),
    .ram_addr_o(ram_addr_b), .ram_wdata_o(ram_wdata_b), .ram_wmask_o(ram_wmask_b),
    .ram_rdata_i(ram_rdata_b), .init_done_o(init_done_b)
  );

  // RAM model for instance A: masked write, 1-cycle read latency
  logic [Dw-1:0] mem [16];
  always @(posedge clk) begin
    if (ram_req) begin
      if (ram_we) mem[ram_addr] <= (mem[ram_addr] & ~ram_wmask) | (ram_wdata & ram_wmask);
      else        ram_rdata <= mem[ram_addr];
    end
  end

  typedef struct {
    int          cyc;
    logic [1:0]  rv;
    logic [31:0] data;
  } rd_exp_t;

  rd_exp_t    exp_rd[$];
  logic [3:0] exp_init[$];

  logic [1:0]  rd_gnt_seq [4];
  logic [31:0] rd_dat_seq [4];
  logic [2:0]  b_seq [6];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: zero-fill writes and read responses of instance A
  always @(negedge clk) begin
    rd_exp_t    e;
    logic [3:0] a;
    if (ram_req && !init_done) begin
      if (exp_init.size() == 0) begin
        total++; bad++;
        $display("FAIL init_extra_write: got addr %0h expected none", ram_addr);
      end else begin
        a = exp_init.pop_front();
        check("init_addr",  64'(ram_addr),  64'(a));
        check("init_we",    64'(ram_we),    64'(1));
        check("init_wdata", 64'(ram_wdata), 64'(0));
        check("init_wmask", 64'(ram_wmask), 64'(32'hFFFF_FFFF));
        check("init_gnt",   64'(gnt),       64'(0));
      end
    end
    if (|rvalid) begin
      if (exp_rd.size() == 0) begin
        total++; bad++;
        $display("FAIL rvalid_unexpected: got rvalid %0b expected none", rvalid);
      end else begin
        e = exp_rd.pop_front();
        check("rd_cycle",  64'(cyc),    64'(e.cyc));
        check("rd_rvalid", 64'(rvalid), 64'(e.rv));
        check("rd_rdata",  64'(rdata),  64'(e.data));
      end
    end
  end

  // Instance B: no zero-fill, 3-way round robin
  initial begin
    int cnt [3];
    int waitc [3];
    int max_wait;
    rst_nb = 1'b0; req_b = '0; we_b = '0; addr_b = '0;
    wdata_b = '0; wmask_b = '0; ram_rdata_b = '0;
    b_seq = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
    cnt = '{0, 0, 0};
    waitc = '{0, 0, 0};
    max_wait = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("b_rst_init_done", 64'(init_done_b), 64'(1));
    check("b_rst_gnt",       64'(gnt_b),       64'(0));
    step();
    rst_nb = 1'b1; req_b = 3'b001; addr_b[0] = 4'h9;
    @(negedge clk);
    check("b_init_done",   64'(init_done_b), 64'(1));
    check("b_first_gnt",   64'(gnt_b),       64'(3'b001));
    check("b_first_req",   64'(ram_req_b),   64'(1));
    check("b_first_addr",  64'(ram_addr_b),  64'(4'h9));
    step();
    req_b = 3'b111;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("b_rr_gnt", 64'(gnt_b), 64'(b_seq[i]));
      for (int j = 0; j < 3; j++) begin
        if (gnt_b[j]) begin
          cnt[j]++;
          waitc[j] = 0;
        end else begin
          waitc[j]++;
          if (waitc[j] > max_wait) max_wait = waitc[j];
        end
      end
    end
    step();
    req_b = '0;
    for (int j = 0; j < 3; j++) check("b_grant_count", 64'(cnt[j]), 64'(2));
    check("b_max_wait", 64'(max_wait), 64'(2));
    @(negedge clk);
    check("b_idle_gnt", 64'(gnt_b), 64'(0));
    b_done = 1'b1;
  end

  // Main stimulus for instance A
  initial begin
    rd_gnt_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
    rd_dat_seq = '{32'h1234_5678, 32'h0000_BEEF, 32'h1234_5678, 32'h0000_BEEF};
    rst_n = 1'b0; req = '0; we = '0; addr = '0; wdata = '0; wmask = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gnt",       64'(gnt),       64'(0));
    check("rst_rvalid",    64'(rvalid),    64'(0));
    check("rst_ram_req",   64'(ram_req),   64'(0));
    check("rst_init_done", 64'(init_done), 64'(0));

    // Zero-fill with requests held high that must be ignored
    for (int a = 0; a < 16; a++) exp_init.push_back(4'(a));
    step();
    rst_n = 1'b1; req = 2'b11;
    @(negedge clk);
    check("init_cycle0_idle", 64'(ram_req), 64'(0));
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      check("init_done_low", 64'(init_done), 64'(0));
    end
    req = '0;
    @(negedge clk);
    check("init_done_c17",   64'(init_done),       64'(1));
    check("init_all_writes", 64'(exp_init.size()), 64'(0));

    // Masked write by requester 0, full write by requester 1
    step();
    req = 2'b01; we = 2'b01; addr[0] = 4'd3;
    wdata[0] = 32'hDEAD_BEEF; wmask[0] = 32'h0000_FFFF;
    @(negedge clk);
    check("wr0_gnt",   64'(gnt),       64'(2'b01));
    check("wr0_we",    64'(ram_we),    64'(1));
    check("wr0_addr",  64'(ram_addr),  64'(4'd3));
    check("wr0_wmask", 64'(ram_wmask), 64'(32'h0000_FFFF));
    step();
    req = 2'b10; we = 2'b10; addr[1] = 4'd5;
    wdata[1] = 32'h1234_5678; wmask[1] = 32'hFFFF_FFFF;
    @(negedge clk);
    check("wr1_gnt",   64'(gnt),       64'(2'b10));
    check("wr1_wdata", 64'(ram_wdata), 64'(32'h1234_5678));

    // Read back the masked word through requester 1
    step();
    req = 2'b10; we = 2'b00; addr[1] = 4'd3;
    exp_rd.push_back('{cyc + 1, 2'b10, 32'h0000_BEEF});
    @(negedge clk);
    check("rd1_gnt", 64'(gnt), 64'(2'b10));

    // Both requesters read back to back
    for (int i = 0; i < 4; i++) begin
      step();
      req = 2'b11; we = 2'b00; addr[0] = 4'd5; addr[1] = 4'd3;
      exp_rd.push_back('{cyc + 1, rd_gnt_seq[i], rd_dat_seq[i]});
      @(negedge clk);
      check("rr_gnt", 64'(gnt), 64'(rd_gnt_seq[i]));
    end
    step();
    req = '0;
    repeat (3) @(negedge clk);
    check("rd_all_seen", 64'(exp_rd.size()), 64'(0));

    // Reset mid-RUN with a read in flight: its rvalid must never appear
    step();
    req = 2'b01; addr[0] = 4'd5;
    @(negedge clk);
    check("inflight_gnt", 64'(gnt), 64'(2'b01));
    #1;
    rst_n = 1'b0; req = '0;
    repeat (2) @(negedge clk);
    check("midrun_rst_rvalid",    64'(rvalid),    64'(0));
    check("midrun_rst_ram_req",   64'(ram_req),   64'(0));
    check("midrun_rst_init_done", 64'(init_done), 64'(0));

    // Restart INIT, then reset again at address 7
    for (int a = 0; a < 8; a++) exp_init.push_back(4'(a));
    step();
    rst_n = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 8; c++) @(negedge clk);
    check("midinit_addr7", 64'(ram_addr), 64'(4'd7));
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("midinit_rst_ram_req", 64'(ram_req),         64'(0));
    check("midinit_consumed",    64'(exp_init.size()), 64'(0));
    for (int a = 0; a < 16; a++) exp_init.push_back(4'(a));
    step();
    rst_n = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 17; c++) @(negedge clk);
    check("reinit_done",   64'(init_done),       64'(1));
    check("reinit_writes", 64'(exp_init.size()), 64'(0));

    // Re-fill cleared the masked word
    step();
    req = 2'b01; we = 2'b00; addr[0] = 4'd3;
    exp_rd.push_back('{cyc + 1, 2'b01, 32'h0000_0000});
    @(negedge clk);
    check("post_gnt", 64'(gnt), 64'(2'b01));
    step();
    req = '0;
    repeat (3) @(negedge clk);
    check("post_rd_seen", 64'(exp_rd.size()), 64'(0));

    for (int t = 0; t < 200 && !b_done; t++) @(negedge clk);
    if (!b_done) begin
      total++; bad++;
      $display("FAIL b_timeout: got not done expected done");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
